// File: rtl/pipe_sel_mux.sv
// pipe_sel_mux: N:1 operand-select multiplexer with a one-cycle registered
// output stage. It tracks valid, supports stall and flush, and keeps a sticky
// flag for illegal select codes.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   In        flattened data inputs; input k is In[k*WIDTH +: WIDTH]
//   Sel       binary select, sampled at the clock edge
//   InValid   qualifies In/Sel this cycle
//   Stall     hold all registered state
//   Flush     invalidate the output stage (overrides Stall)
//   ErrClr    clear SelErr (a simultaneous set wins)
//   Out       registered selected data
//   OutValid  Out holds a valid selection
//   LastSel   Sel value captured with the current Out
//   SelErr    sticky: a valid load presented Sel >= N
module pipe_sel_mux #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      N           = 4,
  parameter int unsigned      SEL_W       = 2,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] In,
  input  logic [SEL_W-1:0]   Sel,
  input  logic               InValid,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               ErrClr,
  output logic [WIDTH-1:0]   Out,
  output logic               OutValid,
  output logic [SEL_W-1:0]   LastSel,
  output logic               SelErr
);

  // Parameter sanity: reject inconsistent configurations at elaboration.
  if (SEL_W != $clog2(N)) begin : g_bad_sel_w
    $error("pipe_sel_mux: SEL_W must equal ceil(log2(N))");
  end
  if (N < 2 || N > 16) begin : g_bad_n
    $error("pipe_sel_mux: N must be in the range 2..16");
  end

  logic [WIDTH-1:0] out_q,     out_d;
  logic             valid_q,   valid_d;
  logic [SEL_W-1:0] lastsel_q, lastsel_d;
  logic             selerr_q,  selerr_d;

  logic             sel_legal_c;
  logic [WIDTH-1:0] sel_data_c;
  logic             load_c;

  // Select decode. The compare is unsigned. Out-of-range codes never reach
  // the part-select.
  always_comb begin
    sel_data_c  = DEFAULT_VAL;
    sel_legal_c = (32'(Sel) < N);
    if (sel_legal_c) begin
      sel_data_c = In[32'(Sel)*WIDTH +: WIDTH];
    end
  end

  assign load_c = !Flush && !Stall;

  // Next-state logic. Priority is Flush, then Stall, then load.
  always_comb begin
    out_d     = out_q;
    valid_d   = valid_q;
    lastsel_d = lastsel_q;
    selerr_d  = selerr_q;

    if (Flush) begin
      out_d     = RESET_VAL;
      valid_d   = 1'b0;
      lastsel_d = '0;
    end else if (!Stall) begin
      // Data loads even when InValid is low, so it tracks the bus.
      out_d     = sel_data_c;
      valid_d   = InValid;
      lastsel_d = Sel;
    end

    // Clear first, so that a simultaneous set takes precedence.
    if (ErrClr) begin
      selerr_d = 1'b0;
    end
    if (load_c && InValid && !sel_legal_c) begin
      selerr_d = 1'b1;
    end
  end

  // Output-stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= RESET_VAL;
      valid_q   <= 1'b0;
      lastsel_q <= '0;
      selerr_q  <= 1'b0;
    end else begin
      out_q     <= out_d;
      valid_q   <= valid_d;
      lastsel_q <= lastsel_d;
      selerr_q  <= selerr_d;
    end
  end

  assign Out      = out_q;
  assign OutValid = valid_q;
  assign LastSel  = lastsel_q;
  assign SelErr   = selerr_q;

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Scoreboard bench for pipe_sel_mux. It runs three configurations side by side:
//   u4: WIDTH=8,  N=4, SEL_W=2
//   u3: WIDTH=8,  N=3, SEL_W=2, DEFAULT_VAL=0xEE
//   u8: WIDTH=16, N=8, SEL_W=3
// Stimulus pushes the expected post-edge state of the DUT under test. A
// monitor pops from the queue and compares just after each rising edge.
module tb_pipe_sel_mux;

  typedef struct packed {
    logic [15:0] out;
    logic        vld;
    logic [2:0]  sel;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, stall, flush, err_clr;

  logic [31:0]  in4;
  logic [1:0]   sel4;
  logic [7:0]   out4;
  logic         vld4, err4;
  logic [1:0]   lsel4;

  logic [23:0]  in3;
  logic [1:0]   sel3;
  logic [7:0]   out3;
  logic         vld3, err3;
  logic [1:0]   lsel3;

  logic [127:0] in8;
  logic [2:0]   sel8;
  logic [15:0]  out8;
  logic         vld8, err8;
  logic [2:0]   lsel8;

  exp_t q4[$];
  exp_t q3[$];
  exp_t q8[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_sel_mux #(.WIDTH(8), .N(4), .SEL_W(2), .RESET_VAL(8'h00), .DEFAULT_VAL(8'h00)) u4 (
    .clk(clk), .rst(rst), .In(in4), .Sel(sel4), .InValid(in_valid), .Stall(stall),
    .Flush(flush), .ErrClr(err_clr), .Out(out4), .OutValid(vld4), .LastSel(lsel4),
    .SelErr(err4));

  pipe_sel_mux #(.WIDTH(8), .N(3), .SEL_W(2), .RESET_VAL(8'h00), .DEFAULT_VAL(8'hEE)) u3 (
    .clk(clk), .rst(rst), .In(in3), .Sel(sel3), .InValid(in_valid), .Stall(stall),
    .Flush(flush), .ErrClr(err_clr), .Out(out3), .OutValid(vld3), .LastSel(lsel3),
    .SelErr(err3));

  pipe_sel_mux #(.WIDTH(16), .N(8), .SEL_W(3), .RESET_VAL(16'h0000), .DEFAULT_VAL(16'h0000)) u8 (
    .clk(clk), .rst(rst), .In(in8), .Sel(sel8), .InValid(in_valid), .Stall(stall),
    .Flush(flush), .ErrClr(err_clr), .Out(out8), .OutValid(vld8), .LastSel(lsel8),
    .SelErr(err8));

  function automatic exp_t mk(input logic [15:0] o, input logic v, input logic [2:0] s,
                              input logic e);
    exp_t r;
    r.out = o;
    r.vld = v;
    r.sel = s;
    r.err = e;
    return r;
  endfunction

  task automatic chk(input string nm, input exp_t act, input exp_t e);
    n_vec++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s @%0t: got out=%h vld=%b sel=%0d err=%b, expected out=%h vld=%b sel=%0d err=%b",
               nm, $time, act.out, act.vld, act.sel, act.err, e.out, e.vld, e.sel, e.err);
    end
  endtask

  // Monitor: the outputs are stable 1 time unit after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) chk("u4", mk(16'(out4), vld4, 3'(lsel4), err4), q4.pop_front());
      if (q3.size() > 0) chk("u3", mk(16'(out3), vld3, 3'(lsel3), err3), q3.pop_front());
      if (q8.size() > 0) chk("u8", mk(out8, vld8, lsel8, err8), q8.pop_front());
    end
  end

  // Watchdog.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] exp2 [4];
    exp2 = '{8'h11, 8'h22, 8'h33, 8'h44};

    rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; err_clr = 1'b0;
    in4 = '0; sel4 = '0; in3 = '0; sel3 = '0; in8 = '0; sel8 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Load 0x5A, then reset asynchronously in the middle of the cycle.
    @(negedge clk);
    in4 = {8'h44, 8'h33, 8'h22, 8'h5A}; sel4 = 2'd0; in_valid = 1'b1;
    q4.push_back(mk(16'h5A, 1'b1, 3'd0, 1'b0));
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("async_reset", mk(16'(out4), vld4, 3'(lsel4), err4), mk(16'h00, 1'b0, 3'd0, 1'b0));
    @(negedge clk);
    rst = 1'b0;

    // Basic select across all four lanes.
    in4 = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int s = 0; s < 4; s++) begin
      if (s > 0) @(negedge clk);
      sel4 = 2'(s);
      q4.push_back(mk(16'(exp2[s]), 1'b1, 3'(s), 1'b0));
    end

    // Stall holds the loaded value, then Flush overrides Stall.
    @(negedge clk);
    sel4 = 2'd2;
    q4.push_back(mk(16'h33, 1'b1, 3'd2, 1'b0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1'b1; sel4 = 2'd0;
      q4.push_back(mk(16'h33, 1'b1, 3'd2, 1'b0));
    end
    @(negedge clk);
    flush = 1'b1;
    q4.push_back(mk(16'h00, 1'b0, 3'd0, 1'b0));
    @(negedge clk);
    stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; sel4 = 2'd1;
    q4.push_back(mk(16'h22, 1'b0, 3'd1, 1'b0));

    // Illegal select on N=3: DEFAULT_VAL is loaded and SelErr sets.
    in3 = {8'h30, 8'h20, 8'h10};
    @(negedge clk);
    in_valid = 1'b1; sel3 = 2'd3;
    q3.push_back(mk(16'hEE, 1'b1, 3'd3, 1'b1));
    @(negedge clk);
    flush = 1'b1; sel3 = 2'd0;
    q3.push_back(mk(16'h00, 1'b0, 3'd0, 1'b1));
    @(negedge clk);
    flush = 1'b0; err_clr = 1'b1; sel3 = 2'd3;
    q3.push_back(mk(16'hEE, 1'b1, 3'd3, 1'b1));
    @(negedge clk);
    sel3 = 2'd0;
    q3.push_back(mk(16'h10, 1'b1, 3'd0, 1'b0));
    @(negedge clk);
    err_clr = 1'b0; in_valid = 1'b0; sel3 = 2'd3;
    q3.push_back(mk(16'hEE, 1'b0, 3'd3, 1'b0));
    @(negedge clk);
    sel3 = 2'd2;
    q3.push_back(mk(16'h30, 1'b0, 3'd2, 1'b0));
    @(negedge clk);
    stall = 1'b1; in_valid = 1'b1; sel3 = 2'd3;
    q3.push_back(mk(16'h30, 1'b0, 3'd2, 1'b0));
    @(negedge clk);
    stall = 1'b0;
    q3.push_back(mk(16'hEE, 1'b1, 3'd3, 1'b1));

    // Wide configuration, with back-to-back selects.
    in8 = '0;
    in8[7*16 +: 16] = 16'hBEEF;
    in8[0*16 +: 16] = 16'h1234;
    in8[3*16 +: 16] = 16'h3333;
    @(negedge clk);
    sel8 = 3'd7;
    q8.push_back(mk(16'hBEEF, 1'b1, 3'd7, 1'b0));
    @(negedge clk);
    sel8 = 3'd0;
    q8.push_back(mk(16'h1234, 1'b1, 3'd0, 1'b0));
    @(negedge clk);
    sel8 = 3'd3;
    q8.push_back(mk(16'h3333, 1'b1, 3'd3, 1'b0));

    // Drain the queues within a bounded number of cycles.
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (q4.size() + q3.size() + q8.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0",
               q4.size() + q3.size() + q8.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_sel_mux.md
Name: pipe_sel_mux

Overview:
Parametrised N:1 operand-select multiplexer with a registered output stage, for use at pipeline-register boundaries (ID/EX operand select, EX/MEM result select).
- Supersedes the fixed 8-bit combinational 2:1 select with configurable width and input count.
- Adds one-cycle registered output, valid tracking, stall/flush control, and sticky detection of illegal select codes.

Parameters:
WIDTH, 8, data width of each input and of the output
N, 4, number of data inputs (legal range 2..16)
SEL_W, 2, select width; must equal ceil(log2(N)); elaboration fails otherwise
RESET_VAL, 0, value of Out after reset and after flush
DEFAULT_VAL, 0, value loaded into Out when Sel >= N

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
In  input  N*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
Sel  input  SEL_W  binary select, sampled at the clock edge
InValid  input  1  qualifies In/Sel this cycle
Stall  input  1  hold all registered state
Flush  input  1  invalidate the output stage
ErrClr  input  1  clear SelErr
Out  output  WIDTH  registered selected data
OutValid  output  1  Out holds a valid selection
LastSel  output  SEL_W  Sel value captured with the current Out
SelErr  output  1  sticky flag: a valid cycle presented Sel >= N

Behaviour:
- Reset: clk and a single asynchronous, active-high reset (rst). While rst is high, all registered outputs clear immediately, independent of clk:
  - Out = RESET_VAL
  - OutValid = 0
  - LastSel = 0
  - SelErr = 0
- Reset mid-operation: any in-flight value is discarded. The first edge after rst deasserts behaves as a normal edge.
- Latency: exactly one cycle. Inputs sampled at edge t appear on Out/OutValid/LastSel after edge t.
- No combinational path from any input to any output.
- Per-edge priority (highest first): rst > Flush > Stall > load.
- Flush:
  - Out = RESET_VAL, OutValid = 0, LastSel = 0.
  - Flush overrides a simultaneous Stall.
  - The SelErr update still applies (see below).
- Stall (Flush = 0): Out, OutValid and LastSel hold. Sel/In are ignored for SelErr purposes.
- Load (Flush = 0, Stall = 0):
  - OutValid = InValid.
  - LastSel = Sel.
  - Out = input[Sel] if Sel < N, else DEFAULT_VAL.
  - Out loads even when InValid = 0, so data tracks the bus. Consumers must gate on OutValid.
- SelErr:
  - Sets on a load edge when InValid = 1 and Sel >= N.
  - Clears on an edge where ErrClr = 1.
  - If set and clear occur on the same edge, set wins and SelErr stays 1.
  - Flush does not clear SelErr.
  - When N is a power of two, Sel >= N is unreachable and SelErr stays 0.
- Width rules:
  - Out is exactly WIDTH bits, with no sign or zero extension.
  - The comparison Sel >= N is unsigned.
- Select decode uses an indexed part-select over the flattened bus. No latches; a full default assignment is required.

Test Plan:
1. Reset values (N=4, WIDTH=8): assert rst asynchronously mid-cycle with Out=0x5A, OutValid=1 -> Out=0x00, OutValid=0, LastSel=0, SelErr=0 immediately, before the next edge.
2. Basic select (N=4): In = {0x44,0x33,0x22,0x11}; InValid=1; Sel = 0,1,2,3 on consecutive edges -> Out = 0x11,0x22,0x33,0x44 one cycle later each, OutValid=1, LastSel matches Sel.
3. Stall/flush: load Sel=2 (Out=0x33), then Stall=1 for 3 cycles while Sel changes to 0 -> Out holds 0x33. Then Stall=1 with Flush=1 on the same edge -> Out=0x00, OutValid=0.
4. Illegal select (N=3, SEL_W=2, DEFAULT_VAL=0xEE): Sel=3 with InValid=1 -> Out=0xEE, SelErr=1.
   - SelErr stays 1 through a subsequent flush.
   - ErrClr=1 together with another illegal Sel -> SelErr stays 1.
   - ErrClr=1 with Sel=0 -> SelErr=0.
5. Invalid data (N=4): InValid=0, Sel=1, In1=0x22 -> Out=0x22, OutValid=0, and SelErr unchanged. With N=3, InValid=0 and Sel=3 -> SelErr stays 0.
6. Wide config (WIDTH=16, N=8, SEL_W=3): Sel=7 with In7=0xBEEF -> Out=0xBEEF after one edge. Back-to-back Sel=7 then Sel=0 (In0=0x1234) -> Out=0xBEEF then 0x1234 on consecutive cycles.
